// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer pixel writer: FSM encoding that
// matches the line drawer's 2-bit master_state, AXI response codes and the
// default framebuffer geometry.
package fb_pkg;

  // Encoding is fixed by the drawer, which waits for 2'b00 before stepping.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_BUS  = 2'b10,
    ST_RESP = 2'b11
  } fb_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

  localparam logic [31:0] FB_BASE_DEF   = 32'h1000_0000;
  localparam int          FB_WIDTH_DEF  = 640;
  localparam int          FB_HEIGHT_DEF = 480;
  localparam int          FB_STRIDE_DEF = 1280;

  // A 16 bpp pixel occupies one half of a 32-bit beat; address bit 1 picks it.
  function automatic logic [3:0] half_strb(input logic sel_hi);
    return sel_hi ? 4'b1100 : 4'b0011;
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational clip test and byte-address / strobe / data generation for
// one pixel. The result is registered by the top while in the ADDR state.
module fb_addr_calc
  import fb_pkg::*;
#(
  parameter logic [31:0] FB_BASE   = FB_BASE_DEF,
  parameter int          FB_WIDTH  = FB_WIDTH_DEF,
  parameter int          FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int          FB_STRIDE = FB_STRIDE_DEF
) (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] data,
  output logic        clip,
  output logic [31:0] awaddr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);

  // One extra bit keeps the bound comparisons signed without overflow.
  localparam logic signed [16:0] W_S      = 17'(FB_WIDTH);
  localparam logic signed [16:0] H_S      = 17'(FB_HEIGHT);
  localparam logic [31:0]        STRIDE_W = 32'(FB_STRIDE);

  logic signed [16:0] xs;
  logic signed [16:0] ys;
  logic [31:0]        byte_a;

  // Clip against the visible window, then form the byte address. y is
  // zero-extended: any negative y has already been clipped, so the address
  // only matters for in-range coordinates.
  always_comb begin
    xs     = $signed({x[15], x});
    ys     = $signed({y[15], y});
    clip   = (xs < 17'sd0) || (xs >= W_S) || (ys < 17'sd0) || (ys >= H_S);
    byte_a = FB_BASE + ({16'd0, y} * STRIDE_W) + {15'd0, x, 1'b0};
    awaddr = byte_a & 32'hFFFF_FFFC;
    wstrb  = half_strb(byte_a[1]);
    wdata  = {data, data};
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel writer: edge-detects the drawer's write strobe, clips the pixel,
// and commits it with one single-beat AXI4 write. master_state and
// writes_done feed back to the drawer so it steps only after commit.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter logic [31:0] FB_BASE   = FB_BASE_DEF,
  parameter int          FB_WIDTH  = FB_WIDTH_DEF,
  parameter int          FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int          FB_STRIDE = FB_STRIDE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pix_addr,
  input  logic [15:0] pix_data,
  input  logic        pix_we,
  output logic [1:0]  master_state,
  output logic        writes_done,
  output logic        overrun,
  output logic        bus_err,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  fb_state_e   state_q, state_d;
  logic        pix_we_q;                 // previous pix_we, for edge detect
  logic [15:0] x_q, x_d, y_q, y_d, data_q, data_d;
  logic        writes_done_q, writes_done_d;
  logic        overrun_q, overrun_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        capture;
  logic        calc_clip;
  logic [31:0] calc_awaddr;
  logic [31:0] calc_wdata;
  logic [3:0]  calc_wstrb;

  fb_addr_calc #(
    .FB_BASE   (FB_BASE),
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .FB_STRIDE (FB_STRIDE)
  ) u_addr_calc (
    .x      (x_q),
    .y      (y_q),
    .data   (data_q),
    .clip   (calc_clip),
    .awaddr (calc_awaddr),
    .wstrb  (calc_wstrb),
    .wdata  (calc_wdata)
  );

  // Next-state and datapath: every register holds unless its state acts on it.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    data_d        = data_q;
    writes_done_d = writes_done_q;
    overrun_d     = overrun_q;
    bus_err_d     = bus_err_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;

    // The drawer holds pix_we for several cycles; only the rise is a request.
    capture = pix_we & ~pix_we_q;

    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          x_d           = pix_addr[31:16];
          y_d           = pix_addr[15:0];
          data_d        = pix_data;
          writes_done_d = 1'b0;
          state_d       = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (calc_clip) begin
          // Off-screen pixels complete without touching the bus.
          writes_done_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          awaddr_d  = calc_awaddr;
          wdata_d   = calc_wdata;
          wstrb_d   = calc_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_BUS;
        end
      end
      ST_BUS: begin
        // AW and W complete independently, possibly in the same cycle.
        if (awvalid_q && m_axi_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_axi_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axi_bvalid && bready_q) begin
          bready_d      = 1'b0;
          writes_done_d = 1'b1;
          if (m_axi_bresp != AXI_RESP_OKAY) bus_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new request while a pixel is in flight is dropped and flagged.
    if (capture && (state_q != ST_IDLE)) overrun_d = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and bus-side registers; reset aborts any transaction at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_we_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      data_q        <= '0;
      writes_done_q <= 1'b0;
      overrun_q     <= 1'b0;
      bus_err_q     <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
    end else begin
      pix_we_q      <= pix_we;
      x_q           <= x_d;
      y_q           <= y_d;
      data_q        <= data_d;
      writes_done_q <= writes_done_d;
      overrun_q     <= overrun_d;
      bus_err_q     <= bus_err_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
    end
  end

  assign master_state  = state_q;
  assign writes_done   = writes_done_q;
  assign overrun       = overrun_q;
  assign bus_err       = bus_err_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: the stimulus side pushes expected
// AXI beats from a plain-arithmetic pixel model; a slave/monitor process
// pops and compares them as the DUT handshakes.
module tb_fb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pix_addr = '0;
  logic [15:0] pix_data = '0;
  logic        pix_we = 1'b0;
  logic [1:0]  master_state;
  logic        writes_done, overrun, bus_err;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;

  fb_pixel_writer dut (
    .clk(clk), .rst_n(rst_n), .pix_addr(pix_addr), .pix_data(pix_data), .pix_we(pix_we),
    .master_state(master_state), .writes_done(writes_done), .overrun(overrun), .bus_err(bus_err),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard queues and slave configuration for the pixel in flight.
  logic [31:0] exp_aw_q[$];
  logic [35:0] exp_w_q[$];
  int          aw_lat = 0, w_lat = 0, b_lat = 0;
  logic [1:0]  b_resp_cfg = 2'b00;
  int          aw_hs_total = 0, b_hs_total = 0;
  logic        model_bus_err = 1'b0, model_overrun = 1'b0;

  // Slave/monitor private state.
  int s_aw_wait = 0, s_w_wait = 0, s_b_wait = 0, s_aw_hi = 0, s_w_hi = 0;
  bit s_aw_seen = 0, s_w_seen = 0, s_b_pend = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // AXI slave and monitor. Readies are set on the falling edge; a valid
  // seen with ready here completes on the following rising edge.
  initial begin : slave_monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        s_aw_wait = 0; s_w_wait = 0; s_b_wait = 0; s_aw_hi = 0; s_w_hi = 0;
        s_aw_seen = 0; s_w_seen = 0; s_b_pend = 0;
      end else begin
        awready = 0;
        if (awvalid) begin
          s_aw_hi++;
          awready = (s_aw_wait >= aw_lat);
          s_aw_wait++;
          if (awready) begin
            check("aw_valid_cycles", 64'(s_aw_hi), 64'(aw_lat + 1));
            if (exp_aw_q.size() == 0) check("aw_unexpected", 1, 0);
            else check("awaddr", awaddr, exp_aw_q.pop_front());
            aw_hs_total++; s_aw_seen = 1; s_aw_wait = 0; s_aw_hi = 0;
          end
        end
        wready = 0;
        if (wvalid) begin
          s_w_hi++;
          wready = (s_w_wait >= w_lat);
          s_w_wait++;
          if (wready) begin
            check("w_valid_cycles", 64'(s_w_hi), 64'(w_lat + 1));
            if (exp_w_q.size() == 0) check("w_unexpected", 1, 0);
            else check("wdata_wstrb", {wdata, wstrb}, exp_w_q.pop_front());
            s_w_seen = 1; s_w_wait = 0; s_w_hi = 0;
          end
        end
        bvalid = 0;
        if (bready) begin
          if (!s_b_pend) begin
            check("bready_after_both", {s_aw_seen, s_w_seen}, 2'b11);
            s_b_pend = 1; s_b_wait = 0;
          end
          if (s_b_wait >= b_lat) begin
            bvalid = 1; bresp = b_resp_cfg; b_hs_total++;
            s_aw_seen = 0; s_w_seen = 0; s_b_pend = 0;
          end else s_b_wait++;
        end
      end
    end
  end

  // Issue one pixel, model its effect, wait for completion and check status.
  // glitch re-raises pix_we while the bus is busy to provoke an overrun.
  task automatic send_pixel(input int x, input int y, input logic [15:0] d,
                            input int awl, input int wl, input int bl,
                            input logic [1:0] br, input bit glitch);
    logic [31:0] ba;
    logic [15:0] xs, ys;
    bit          clip;
    int          n, aw_before;
    xs = x[15:0];
    ys = y[15:0];
    aw_lat = awl; w_lat = wl; b_lat = bl; b_resp_cfg = br;
    clip = (x < 0) || (x >= 640) || (y < 0) || (y >= 480);
    if (!clip) begin
      ba = 32'h1000_0000 + 32'(y * 1280 + x * 2);
      exp_aw_q.push_back(ba & 32'hFFFF_FFFC);
      exp_w_q.push_back({d, d, ((ba % 4) >= 2) ? 4'b1100 : 4'b0011});
      if (br != 2'b00) model_bus_err = 1'b1;
    end
    aw_before = aw_hs_total;
    @(negedge clk);
    pix_addr = {xs, ys}; pix_data = d; pix_we = 1'b1;
    @(negedge clk);
    n = 1;
    check("state_addr_after_capture", master_state, 2'b01);
    check("done_clear_on_capture", writes_done, 1'b0);
    while (!(writes_done && master_state == 2'b00) && n < 300) begin
      @(negedge clk);
      n++;
      if (glitch) begin
        if (n == 2) pix_we = 1'b0;
        if (n == 3) begin pix_we = 1'b1; model_overrun = 1'b1; end
        if (n == 5) pix_we = 1'b0;
      end else if (n == 3) pix_we = 1'b0;
    end
    check("done_timeout", 64'(n < 300), 1);
    if (awl == 0 && wl == 0 && bl == 0 && !glitch)
      check("done_latency", 64'(n), clip ? 64'd2 : 64'd4);
    pix_we = 1'b0;
    @(negedge clk);
    check("done_held_idle", {master_state, writes_done}, 3'b001);
    check("bus_err", bus_err, model_bus_err);
    check("overrun", overrun, model_overrun);
    check("aw_count", 64'(aw_hs_total - aw_before), clip ? 64'd0 : 64'd1);
    check("aw_queue_drained", 64'(exp_aw_q.size() + exp_w_q.size()), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {master_state, writes_done, overrun, bus_err, awvalid, wvalid, bready, awaddr, wdata, wstrb},
          '0);
    rst_n = 1'b1;
    @(negedge clk);

    send_pixel(3, 2, 16'hF800, 0, 0, 0, 2'b00, 0);      // 0x1000_0A04, 1100
    send_pixel(0, 0, 16'h07E0, 0, 0, 0, 2'b00, 0);      // 0x1000_0000, 0011
    send_pixel(1, 0, 16'h001F, 0, 0, 0, 2'b00, 0);      // 0x1000_0000, 1100
    send_pixel(-1, 5, 16'h1234, 0, 0, 0, 2'b00, 0);     // clipped
    send_pixel(640, 0, 16'h4321, 0, 0, 0, 2'b00, 0);    // clipped
    send_pixel(639, 479, 16'hBEEF, 0, 0, 0, 2'b00, 0);  // last visible pixel
    send_pixel(0, 480, 16'hBEEF, 0, 0, 0, 2'b00, 0);    // clipped
    send_pixel(10, 10, 16'hA5A5, 5, 0, 0, 2'b00, 0);    // AW stalls 5 cycles
    send_pixel(12, 7, 16'h5A5A, 0, 4, 2, 2'b00, 0);     // W and B stall
    send_pixel(20, 20, 16'hCAFE, 0, 0, 0, 2'b10, 0);    // SLVERR -> bus_err
    send_pixel(21, 20, 16'hCAFF, 0, 0, 0, 2'b00, 0);    // bus_err stays set
    send_pixel(30, 40, 16'h0F0F, 6, 1, 0, 2'b00, 1);    // overrun during BUS

    // Reset while waiting for B: all outputs must clear before any edge.
    aw_lat = 0; w_lat = 0; b_lat = 20; b_resp_cfg = 2'b00;
    exp_aw_q.push_back(32'h1000_0000 + 32'(9 * 1280 + 8 * 2));
    exp_w_q.push_back({16'h7777, 16'h7777, 4'b0011});
    @(negedge clk);
    pix_addr = {16'd8, 16'd9}; pix_data = 16'h7777; pix_we = 1'b1;
    n = 0;
    while (master_state != 2'b11 && n < 50) begin @(negedge clk); n++; end
    check("reach_resp", 64'(n < 50), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {master_state, writes_done, overrun, bus_err, awvalid, wvalid, bready, awaddr, wdata, wstrb},
          '0);
    pix_we = 1'b0;
    exp_aw_q.delete(); exp_w_q.delete();
    model_bus_err = 1'b0; model_overrun = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomised pixels, some off-screen, random stalls and error responses.
    for (int i = 0; i < 40; i++) begin
      int rx, ry, al, wl, bl;
      logic [1:0] br;
      rx = int'($urandom_range(0, 719)) - 40;
      ry = int'($urandom_range(0, 539)) - 30;
      al = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3));
      wl = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3));
      bl = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3));
      br = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_pixel(rx, ry, 16'($urandom), al, wl, bl, br, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
